// File: rtl/fp_math_pkg.sv
// ============================================================================
//  Module      : fp_math_pkg
//  Description : Shared single-precision constants, unit latencies and the
//                round-and-pack helper used by the float math cores.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_math_pkg;

  localparam logic [31:0] ONE          = 32'h3f800000;
  localparam logic [31:0] HALF         = 32'h3f000000;
  localparam logic [31:0] SIXTH        = 32'h3e2aaaab;
  localparam logic [31:0] TWENTYFOURTH = 32'h3d2aaaab;

  localparam int MULT_LAT = 11;
  localparam int ADD_LAT  = 14;
  localparam int EXP_LAT  = 62;

  // Round-to-nearest-even on a 24-bit significand (hidden bit included),
  // then pack; out-of-range exponents saturate to inf or flush to zero.
  function automatic logic [31:0] fp_pack(input logic sign,
                                          input logic signed [9:0] e,
                                          input logic [23:0] m24,
                                          input logic g,
                                          input logic s);
    logic [24:0]       r;
    logic signed [9:0] ef;
    r  = {1'b0, m24} + {24'b0, (g & (s | m24[0]))};
    ef = r[24] ? e + 10'sd1 : e;
    if (ef >= 10'sd255) return {sign, 8'hff, 23'b0};
    if (ef <= 10'sd0)   return {sign, 31'b0};
    return {sign, ef[7:0], (r[24] ? r[23:1] : r[22:0])};
  endfunction

endpackage

`default_nettype wire

// File: rtl/add.sv
// ============================================================================
//  Module      : add
//  Description : Single-precision adder, fixed ADD_LAT latency, RNE.
//                Denormals flush to zero; pipeline is intentionally unreset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add
  import fp_math_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  logic [31:0]       w_big, w_sml;
  logic [23:0]       w_mb, w_ms;
  logic [7:0]        w_d;
  logic [50:0]       w_sfull, w_sh;
  logic              w_stk;
  logic [51:0]       w_sum, w_norm;
  logic [5:0]        w_lead;
  logic signed [9:0] w_e;
  logic [31:0]       w_res;
  logic [31:0]       r_pipe [ADD_LAT];

  // Align the smaller magnitude (27 guard bits + sticky), add/subtract,
  // renormalise on the leading one and round.
  always_comb begin
    if (b[30:0] > a[30:0]) begin
      w_big = b; w_sml = a;
    end else begin
      w_big = a; w_sml = b;
    end
    w_mb    = (w_big[30:23] != 8'd0) ? {1'b1, w_big[22:0]} : 24'd0;
    w_ms    = (w_sml[30:23] != 8'd0) ? {1'b1, w_sml[22:0]} : 24'd0;
    w_d     = w_big[30:23] - w_sml[30:23];
    w_sfull = {w_ms, 27'b0};
    if (w_d > 8'd50) begin
      w_sh  = '0;
      w_stk = |w_ms;
    end else begin
      w_sh  = w_sfull >> w_d;
      w_stk = |(w_sfull & ((51'd1 << w_d) - 51'd1));
    end
    w_sh[0] = w_sh[0] | w_stk;
    w_sum   = (w_big[31] ^ w_sml[31]) ? {1'b0, w_mb, 27'b0} - {1'b0, w_sh}
                                      : {1'b0, w_mb, 27'b0} + {1'b0, w_sh};
    w_lead  = 6'd0;
    for (int i = 0; i < 52; i++) if (w_sum[i]) w_lead = 6'(i);
    w_norm  = w_sum << (6'd51 - w_lead);
    w_e     = $signed({2'b00, w_big[30:23]}) + $signed({4'b0000, w_lead}) - 10'sd50;
    w_res   = fp_pack(w_big[31], w_e, w_norm[51:28], w_norm[27], |w_norm[26:0]);
    if (w_sum == 52'd0) w_res = 32'd0;
  end

  // Latency pipeline; contents are qualified downstream by the done chain.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_res;
    for (int i = 1; i < ADD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign out = r_pipe[ADD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/mult.sv
// ============================================================================
//  Module      : mult
//  Description : Single-precision multiplier, fixed MULT_LAT latency, RNE.
//                Denormals flush to zero; pipeline is intentionally unreset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult
  import fp_math_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  logic              w_sign;
  logic [47:0]       w_p;
  logic signed [9:0] w_e;
  logic [31:0]       w_res;
  logic [31:0]       r_pipe [MULT_LAT];

  // Significand product, normalise by one bit if it reached [2,4), round.
  always_comb begin
    w_sign = a[31] ^ b[31];
    w_p    = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    w_e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (w_p[47]) w_res = fp_pack(w_sign, w_e + 10'sd1, w_p[47:24], w_p[23], |w_p[22:0]);
    else         w_res = fp_pack(w_sign, w_e, w_p[46:23], w_p[22], |w_p[21:0]);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) w_res = {w_sign, 31'b0};
  end

  // Latency pipeline; contents are qualified downstream by the done chain.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_res;
    for (int i = 1; i < MULT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign out = r_pipe[MULT_LAT-1];

endmodule

`default_nettype wire

// File: rtl/pipe_delay.sv
// ============================================================================
//  Module      : pipe_delay
//  Description : Fixed-depth alignment shift register, async active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the input through DEPTH stages; reset clears every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/exp_fast_core.sv
// ============================================================================
//  Module      : exp_fast_core
//  Description : Fully pipelined exp(x) for |x| <= 1.0 via the 5-term Taylor
//                series; one operand per clock, fixed EXP_LAT latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_fast_core
  import fp_math_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  input  logic        start,
  output logic [31:0] exp,
  output logic        done,
  output logic        error
);

  logic        w_err0;
  logic [31:0] w_x11, w_e2, w_e3, w_t2, w_e4, w_t3, w_t4;
  logic [31:0] w_s01, w_s01_d, w_s012, w_s012_d, w_s34, w_sum;

  // Magnitude bits above 1.0 (including Inf/NaN) are out of range.
  assign w_err0 = ({1'b0, x[30:0]} > ONE);

  // Powers and scaled terms; cycle of each result noted on the right.
  mult u_e2 (.clk(clk), .a(x),    .b(x),            .out(w_e2));  // @11
  mult u_e3 (.clk(clk), .a(w_e2), .b(w_x11),        .out(w_e3));  // @22
  mult u_t2 (.clk(clk), .a(w_e2), .b(HALF),         .out(w_t2));  // @22
  mult u_e4 (.clk(clk), .a(w_e2), .b(w_e2),         .out(w_e4));  // @22
  mult u_t3 (.clk(clk), .a(w_e3), .b(SIXTH),        .out(w_t3));  // @33
  mult u_t4 (.clk(clk), .a(w_e4), .b(TWENTYFOURTH), .out(w_t4));  // @33

  // Partial sums folded into a balanced tree.
  add u_s01  (.clk(clk), .a(ONE),      .b(x),     .out(w_s01));   // @14
  add u_s012 (.clk(clk), .a(w_s01_d),  .b(w_t2),  .out(w_s012));  // @36
  add u_s34  (.clk(clk), .a(w_t3),     .b(w_t4),  .out(w_s34));   // @47
  add u_sum  (.clk(clk), .a(w_s012_d), .b(w_s34), .out(w_sum));   // @61

  // Alignment chains that line operands up with their partner terms.
  pipe_delay #(.WIDTH(32), .DEPTH(MULT_LAT)) u_dly_x
    (.clk(clk), .rst_n(rst_n), .i_data(x), .o_data(w_x11));
  pipe_delay #(.WIDTH(32), .DEPTH(2*MULT_LAT - ADD_LAT)) u_dly_s01
    (.clk(clk), .rst_n(rst_n), .i_data(w_s01), .o_data(w_s01_d));
  pipe_delay #(.WIDTH(32), .DEPTH(3*MULT_LAT + ADD_LAT - 2*MULT_LAT - ADD_LAT)) u_dly_s012
    (.clk(clk), .rst_n(rst_n), .i_data(w_s012), .o_data(w_s012_d));
  pipe_delay #(.WIDTH(2), .DEPTH(EXP_LAT)) u_dly_flags
    (.clk(clk), .rst_n(rst_n), .i_data({start, w_err0}), .o_data({done, error}));

  // Output register loads every cycle; consumers qualify it with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp <= 32'd0;
    else        exp <= w_sum;
  end

endmodule

`default_nettype wire
